// File: rtl/synth_pkg.sv
// Shared frame layout and waveform-mode type for poly_tone_synth.
// Mode 10 decodes to TRI only when POLY_TONE_SYNTH_TRIANGLE_EN is defined.
package synth_pkg;

    localparam int FRAME_W  = 32;
    localparam int GATE_BIT = 31;
    localparam int VOICE_HI = 30;
    localparam int VOICE_LO = 28;
    localparam int MODE_HI  = 25;
    localparam int MODE_LO  = 24;
    localparam int INCR_LO  = 0;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10
    } mode_t;

    // Code 11, and 10 when the triangle is compiled out, collapse onto SQUARE.
    function automatic mode_t decode_mode(input logic [1:0] code);
        mode_t m;
        m = SQUARE;
        if (code == 2'b01) m = SAW;
`ifdef POLY_TONE_SYNTH_TRIANGLE_EN
        else if (code == 2'b10) m = TRI;
`endif
        return m;
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI slave front end: synchronizes sck/sdi/load into clk, shifts 32-bit frames
// and emits either a one-clk frame_valid or a one-clk frame_err per frame.
module spi_frame_rx
    import synth_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    input  logic               load,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    output logic               frame_err
);

    // Bits [1:0] are the synchronizer; bit [2] holds the previous synced value for edge detection.
    logic [2:0]         sck_sync;
    logic [2:0]         load_sync;
    logic [1:0]         sdi_sync;
    logic [FRAME_W-1:0] shift_reg;
    logic [5:0]         bit_cnt;
    logic               sck_rise;
    logic               load_fall;

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign load_fall = ~load_sync[1] & load_sync[2];
    assign frame     = shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync    <= '0;
            load_sync   <= '0;
            sdi_sync    <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[1:0], sck};
            load_sync   <= {load_sync[1:0], load};
            sdi_sync    <= {sdi_sync[0], sdi};
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (load_fall) begin
                frame_valid <= (bit_cnt == 6'd32);
                frame_err   <= (bit_cnt != 6'd32);
                bit_cnt     <= '0;
            end else if (load_sync[1] && sck_rise) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], sdi_sync[1]};
                if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic tone synthesizer: SPI-programmed phase-accumulator voices mixed into one sample.
// Define POLY_TONE_SYNTH_TRIANGLE_EN to build the triangle waveform for mode 10.
module poly_tone_synth
    import synth_pkg::*;
#(
    parameter int NVOICES    = 4,
    parameter int PHASE_W    = 24,
    parameter int WAVE_W     = 8,
    parameter int SAMPLE_DIV = 2500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    input  logic               load,
    output logic [WAVE_W-1:0]  wave,
    output logic [NVOICES-1:0] active,
    output logic               frame_err
);

    localparam int SHIFT = $clog2(NVOICES);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int SUM_W = WAVE_W + SHIFT;
    localparam logic [WAVE_W-1:0] MIDSCALE = {1'b1, {(WAVE_W-1){1'b0}}};

    logic [FRAME_W-1:0] frame;
    logic               frame_valid;

    spi_frame_rx u_rx (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .load        (load),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    logic               new_gate;
    logic [2:0]         voice_idx;
    mode_t              new_mode;
    logic [PHASE_W-1:0] new_incr;
    logic               unused_frame;

    assign new_gate     = frame[GATE_BIT];
    assign voice_idx    = frame[VOICE_HI:VOICE_LO];
    assign new_mode     = decode_mode(frame[MODE_HI:MODE_LO]);
    assign new_incr     = frame[INCR_LO +: PHASE_W];
    assign unused_frame = ^frame;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             tick_d1;
    logic             tick_d2;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            tick_d1 <= tick;
            tick_d2 <= tick_d1;
        end
    end

    logic [PHASE_W-1:0] phase [NVOICES];
    logic [PHASE_W-1:0] incr  [NVOICES];
    mode_t              mode  [NVOICES];
    logic [NVOICES-1:0] gate;

    // The tick advance uses the pre-commit increment; a fresh gate-on then overrides it with a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NVOICES; v++) begin
                phase[v] <= '0;
                incr[v]  <= '0;
                mode[v]  <= SQUARE;
            end
            gate <= '0;
        end else begin
            for (int v = 0; v < NVOICES; v++) begin
                if (tick && gate[v]) phase[v] <= phase[v] + incr[v];
                if (frame_valid && voice_idx == 3'(v)) begin
                    gate[v] <= new_gate;
                    mode[v] <= new_mode;
                    incr[v] <= new_incr;
                    if (new_gate && !gate[v]) phase[v] <= '0;
                end
            end
        end
    end

    assign active = gate;

    function automatic logic [WAVE_W-1:0] voice_sample(input logic [PHASE_W-1:0] ph,
                                                       input mode_t m, input logic g);
        logic [WAVE_W-1:0] p;
        logic [WAVE_W-1:0] result;
        p      = ph[PHASE_W-1 -: WAVE_W];
        result = {WAVE_W{p[WAVE_W-1]}};
        if (!g) result = MIDSCALE;
        else if (m == SAW) result = p;
`ifdef POLY_TONE_SYNTH_TRIANGLE_EN
        else if (m == TRI) result = p[WAVE_W-1] ? ~{p[WAVE_W-2:0], 1'b0} : {p[WAVE_W-2:0], 1'b0};
`endif
        return result;
    endfunction

    logic [WAVE_W-1:0] sample [NVOICES];
    logic [SUM_W-1:0]  sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NVOICES; v++) sample[v] <= MIDSCALE;
        end else if (tick_d1) begin
            for (int v = 0; v < NVOICES; v++) sample[v] <= voice_sample(phase[v], mode[v], gate[v]);
        end
    end

    always_comb begin
        sum = '0;
        for (int v = 0; v < NVOICES; v++) sum = sum + SUM_W'(sample[v]);
    end

    always_ff @(posedge clk) begin
        if (reset) wave <= MIDSCALE;
        else if (tick_d2) wave <= sum[SUM_W-1:SHIFT];
    end

endmodule
